// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall against a two-slot EX/MEM dest scoreboard,
// branch-resolution FSM for bne, and saturating stall/taken-branch counters.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [15:0]      id_inst,
   input  logic             mem_pc_src,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] branches_taken,
   output logic [1:0]       state
);

   // state  | meaning
   // RUN    | normal issue; RAW stalls and bne entry decided here
   // BR_EX  | bne in EX, fetch frozen, IF_ID loads NOP
   // BR_MEM | bne in MEM, mem_pc_src selects fall-through or target
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BR_EX  = 2'd1,
      BR_MEM = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic             ex_v_q, ex_v_d, mem_v_q, mem_v_d;
   logic [3:0]       ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, br_cnt_q, br_cnt_d;

   logic [3:0] opcode, rs, rt, rd, wr_dst;
   logic       rd_rs, rd_rt, wr, is_bne, hazard, br_taken;

   always_comb begin
      opcode = id_inst[15:12];
      rs     = id_inst[11:8];
      rt     = id_inst[7:4];
      rd     = id_inst[3:0];
      rd_rs  = 1'b0;
      rd_rt  = 1'b0;
      wr     = 1'b0;
      wr_dst = rd;
      case (opcode)
         4'h0, 4'h1, 4'h2, 4'h6, 4'h7: begin
            rd_rs = 1'b1;
            rd_rt = 1'b1;
            wr    = 1'b1;
         end
         4'h8: begin
            rd_rs  = 1'b1;
            wr     = 1'b1;
            wr_dst = rt;
         end
         4'hA, 4'hE: begin
            rd_rs = 1'b1;
            rd_rt = 1'b1;
         end
         default: ;
      endcase
      is_bne = (opcode == 4'hE);
      // No forwarding, so any pending write in EX or MEM blocks the read.
      hazard = (rd_rs && ((ex_v_q && ex_dst_q == rs) || (mem_v_q && mem_dst_q == rs))) ||
               (rd_rt && ((ex_v_q && ex_dst_q == rt) || (mem_v_q && mem_dst_q == rt)));
   end

   always_comb begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
      br_taken     = 1'b0;
      state_d      = state_q;
      if (clear) begin
         case (state_q)
            RUN: begin
               if (!hazard) begin
                  if_id_en     = 1'b1;
                  id_ex_bubble = 1'b0;
                  if (is_bne) begin
                     if_id_flush = 1'b1;
                     state_d     = BR_EX;
                  end else begin
                     pc_en = 1'b1;
                  end
               end
            end
            BR_EX: begin
               if_id_en     = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b0;
               state_d      = BR_MEM;
            end
            BR_MEM: begin
               pc_en        = 1'b1;
               if_id_en     = 1'b1;
               if_id_flush  = mem_pc_src;
               id_ex_bubble = 1'b0;
               br_taken     = mem_pc_src;
               state_d      = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      ex_v_d      = wr && !id_ex_bubble;
      ex_dst_d    = wr_dst;
      mem_v_d     = ex_v_q;
      mem_dst_d   = ex_dst_q;
      stall_cnt_d = (!pc_en && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
      br_cnt_d    = (br_taken && br_cnt_q != CNT_MAX) ? br_cnt_q + CNT_ONE : br_cnt_q;
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q     <= RUN;
         ex_v_q      <= 1'b0;
         ex_dst_q    <= 4'h0;
         mem_v_q     <= 1'b0;
         mem_dst_q   <= 4'h0;
         stall_cnt_q <= '0;
         br_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         ex_v_q      <= ex_v_d;
         ex_dst_q    <= ex_dst_d;
         mem_v_q     <= mem_v_d;
         mem_dst_q   <= mem_dst_d;
         stall_cnt_q <= stall_cnt_d;
         br_cnt_q    <= br_cnt_d;
      end
   end

   assign stall_cycles   = stall_cnt_q;
   assign branches_taken = br_cnt_q;
   assign state          = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares against a 16-bit and a 2-bit-counter instance.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] id_inst = 16'hF000;
   logic        mem_pc_src = 1'b0;

   logic        pc_en, if_id_en, if_id_flush, id_ex_bubble;
   logic [15:0] stall_cycles, branches_taken;
   logic [1:0]  state;

   logic        pc_en_s, if_id_en_s, if_id_flush_s, id_ex_bubble_s;
   logic [1:0]  stall_cycles_s, branches_taken_s;
   logic [1:0]  state_s;

   int errors = 0;
   int checks = 0;
   int vec_no = 0;

   typedef struct {
      int         idx;
      logic [3:0] ctl;
      logic [1:0] st;
      int         stall;
      int         br;
   } exp_t;

   exp_t exp_q[$];

   hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .clear(clear), .id_inst(id_inst), .mem_pc_src(mem_pc_src),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .stall_cycles(stall_cycles),
      .branches_taken(branches_taken), .state(state)
   );

   hazard_ctrl #(.CNT_W(2)) dut_sat (
      .clk(clk), .clear(clear), .id_inst(id_inst), .mem_pc_src(mem_pc_src),
      .pc_en(pc_en_s), .if_id_en(if_id_en_s), .if_id_flush(if_id_flush_s),
      .id_ex_bubble(id_ex_bubble_s), .stall_cycles(stall_cycles_s),
      .branches_taken(branches_taken_s), .state(state_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ctl{pc,en,fl,bub}", e.idx, int'({pc_en, if_id_en, if_id_flush, id_ex_bubble}), int'(e.ctl));
            chk("state", e.idx, int'(state), int'(e.st));
            chk("stall_cycles", e.idx, int'(stall_cycles), e.stall);
            chk("branches_taken", e.idx, int'(branches_taken), e.br);
            chk("sat_ctl", e.idx, int'({pc_en_s, if_id_en_s, if_id_flush_s, id_ex_bubble_s}), int'(e.ctl));
            chk("sat_state", e.idx, int'(state_s), int'(e.st));
            chk("sat_stall_cycles", e.idx, int'(stall_cycles_s), (e.stall > 3) ? 3 : e.stall);
            chk("sat_branches_taken", e.idx, int'(branches_taken_s), (e.br > 3) ? 3 : e.br);
         end
      end
   end

   task automatic push(input logic [3:0] ctl, input logic [1:0] st, input int stall, input int br);
      exp_t e;
      e.idx = vec_no;
      e.ctl = ctl;
      e.st = st;
      e.stall = stall;
      e.br = br;
      exp_q.push_back(e);
      vec_no++;
   endtask

   task automatic step(input logic [15:0] inst, input logic src, input logic [3:0] ctl,
                       input logic [1:0] st, input int stall, input int br);
      @(posedge clk);
      #1;
      id_inst = inst;
      mem_pc_src = src;
      push(ctl, st, stall, br);
   endtask

   // ctl = {pc_en, if_id_en, if_id_flush, id_ex_bubble}
   localparam logic [3:0] GO  = 4'b1100;
   localparam logic [3:0] STL = 4'b0001;
   localparam logic [3:0] BRF = 4'b0110;
   localparam logic [3:0] TKN = 4'b1110;

   task automatic do_reset();
      @(posedge clk);
      #1;
      clear = 1'b0;
      id_inst = 16'hF000;
      mem_pc_src = 1'b0;
      push(STL, 2'd0, 0, 0);
      @(posedge clk);
      #1;
      push(STL, 2'd0, 0, 0);
      @(posedge clk);
      #1;
      clear = 1'b1;
      push(GO, 2'd0, 0, 0);
   endtask

   initial begin
      do_reset();
      // reset asserted while in BR_EX with a nonzero stall count
      step(16'hE12F, 1'b0, BRF, 2'd0, 0, 0);
      do_reset();
      step(16'h2123, 1'b0, GO,  2'd0, 0, 0);
      // adjacent RAW producer: two stalls
      step(16'h0334, 1'b0, STL, 2'd0, 0, 0);
      step(16'h0334, 1'b0, STL, 2'd0, 1, 0);
      step(16'h0334, 1'b0, GO,  2'd0, 2, 0);
      step(16'hF000, 1'b0, GO,  2'd0, 2, 0);
      step(16'hF000, 1'b0, GO,  2'd0, 2, 0);
      // load-use
      do_reset();
      step(16'h8150, 1'b0, GO,  2'd0, 0, 0);
      step(16'hA251, 1'b0, STL, 2'd0, 0, 0);
      step(16'hA251, 1'b0, STL, 2'd0, 1, 0);
      step(16'hA251, 1'b0, GO,  2'd0, 2, 0);
      // one instruction between producer and consumer
      do_reset();
      step(16'h8150, 1'b0, GO,  2'd0, 0, 0);
      step(16'h2677, 1'b0, GO,  2'd0, 0, 0);
      step(16'hA251, 1'b0, STL, 2'd0, 0, 0);
      step(16'hA251, 1'b0, GO,  2'd0, 1, 0);
      // independent stream
      do_reset();
      step(16'h2123, 1'b0, GO,  2'd0, 0, 0);
      step(16'h2456, 1'b0, GO,  2'd0, 0, 0);
      step(16'h0789, 1'b0, GO,  2'd0, 0, 0);
      step(16'h1ABC, 1'b0, GO,  2'd0, 0, 0);
      step(16'hF000, 1'b0, GO,  2'd0, 0, 0);
      // bne not taken
      do_reset();
      step(16'hE12F, 1'b0, BRF, 2'd0, 0, 0);
      step(16'hF000, 1'b0, BRF, 2'd1, 1, 0);
      step(16'hF000, 1'b0, GO,  2'd2, 2, 0);
      step(16'hF000, 1'b0, GO,  2'd0, 2, 0);
      // bne taken; mem_pc_src high outside BR_MEM must be ignored
      step(16'hE12F, 1'b1, BRF, 2'd0, 2, 0);
      step(16'hF000, 1'b1, BRF, 2'd1, 3, 0);
      step(16'hF000, 1'b1, TKN, 2'd2, 4, 0);
      step(16'hF000, 1'b0, GO,  2'd0, 4, 1);
      step(16'h2123, 1'b1, GO,  2'd0, 4, 1);
      // RAW on bne, then not-taken branch; followed by more stalls to saturate 2-bit counter
      do_reset();
      step(16'h2123, 1'b0, GO,  2'd0, 0, 0);
      step(16'hE132, 1'b0, STL, 2'd0, 0, 0);
      step(16'hE132, 1'b0, STL, 2'd0, 1, 0);
      step(16'hE132, 1'b0, BRF, 2'd0, 2, 0);
      step(16'hF000, 1'b0, BRF, 2'd1, 3, 0);
      step(16'hF000, 1'b0, GO,  2'd2, 4, 0);
      step(16'hF000, 1'b0, GO,  2'd0, 4, 0);
      step(16'h2123, 1'b0, GO,  2'd0, 4, 0);
      step(16'h0334, 1'b0, STL, 2'd0, 4, 0);
      step(16'h0334, 1'b0, STL, 2'd0, 5, 0);
      step(16'h0334, 1'b0, GO,  2'd0, 6, 0);
      step(16'hF000, 1'b0, GO,  2'd0, 6, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
